direction_stepper: RTL and testbench

//  Consumes the prioritised direction/mode word from the signal mux and turns it

---
 rtl/dir_pkg.sv | 9 +
 rtl/step_tick_gen.sv | 15 +
 rtl/direction_stepper.sv | 77 +++++++
 tb/tb_direction_stepper.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dir_pkg.sv
// dir_pkg: one-hot direction codes and mode type shared by the mux, stepper and display.
package dir_pkg;
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;
    typedef enum logic {MODE_HOLD, MODE_LATCH} mode_t;
endpackage

// File: rtl/step_tick_gen.sv
// step_tick_gen: free-running 0..STEP_DIV-1 counter with a one-cycle tick at the top count.
module step_tick_gen #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int CW = $clog2(STEP_DIV);
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(STEP_DIV - 1);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else          cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/direction_stepper.sv
// direction_stepper: synchronises the mux direction/mode word and steps a wrapping
// grid cursor once per tick along the effective heading (HOLD or LATCH mode).
module direction_stepper
    import dir_pkg::*;
#(
    parameter int GRID_W   = 8,
    parameter int GRID_H   = 8,
    parameter int STEP_DIV = 4,
    parameter int START_X  = 0,
    parameter int START_Y  = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [3:0]                direction_in,
    input  logic                      mode_switch_in,
    output logic [$clog2(GRID_W)-1:0] pos_x,
    output logic [$clog2(GRID_H)-1:0] pos_y,
    output logic                      mode_out,
    output logic [3:0]                heading_out,
    output logic                      step_pulse
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    logic [4:0]    sync1, sync2;
    logic          mode_prev, toggle, valid, tick, step;
    logic [3:0]    dir_s, latch, latch_n, heading_n;
    mode_t         mode_q, mode_n;
    logic [XW-1:0] x_n;
    logic [YW-1:0] y_n;

    step_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (.clk(clk), .reset_n(reset_n), .tick(tick));

    assign dir_s    = sync2[3:0];
    assign mode_out = mode_q;

    // A valid direction entering LATCH mode on the toggle cycle wins over the clear.
    always_comb begin
        toggle    = sync2[4] & ~mode_prev;
        valid     = $onehot(dir_s);
        mode_n    = toggle ? (mode_q == MODE_HOLD ? MODE_LATCH : MODE_HOLD) : mode_q;
        latch_n   = (valid && (!toggle || mode_n == MODE_LATCH)) ? dir_s : toggle ? DIR_NONE : latch;
        heading_n = mode_n == MODE_LATCH ? latch_n : valid ? dir_s : DIR_NONE;
        step      = tick && heading_out != DIR_NONE;
        x_n = heading_out == DIR_LEFT  ? (pos_x == '0 ? X_MAX : pos_x - XW'(1)) :
              heading_out == DIR_RIGHT ? (pos_x == X_MAX ? '0 : pos_x + XW'(1)) : pos_x;
        y_n = heading_out == DIR_UP    ? (pos_y == '0 ? Y_MAX : pos_y - YW'(1)) :
              heading_out == DIR_DOWN  ? (pos_y == Y_MAX ? '0 : pos_y + YW'(1)) : pos_y;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            mode_prev   <= 1'b0;
            mode_q      <= MODE_HOLD;
            latch       <= DIR_NONE;
            heading_out <= DIR_NONE;
            pos_x       <= XW'(START_X);
            pos_y       <= YW'(START_Y);
            step_pulse  <= 1'b0;
        end else begin
            sync1       <= {mode_switch_in, direction_in};
            sync2       <= sync1;
            mode_prev   <= sync2[4];
            mode_q      <= mode_n;
            latch       <= latch_n;
            heading_out <= heading_n;
            step_pulse  <= step;
            if (step) begin
                pos_x <= x_n;
                pos_y <= y_n;
            end
        end
endmodule

// File: tb/tb_direction_stepper.sv
// tb_direction_stepper: directed checks of stepping, wrap, HOLD/LATCH modes and async reset.
module tb_direction_stepper;
    import dir_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] dir = 4'b0000;
    logic       msw = 1'b0;
    logic [2:0] px, py;
    logic       mo, sp;
    logic [3:0] hd;
    int compared = 0;
    int mismatched = 0;
    int pulses = 0;

    direction_stepper #(.GRID_W(8), .GRID_H(8), .STEP_DIV(4), .START_X(0), .START_Y(0)) dut (
        .clk(clk), .reset_n(reset_n), .direction_in(dir), .mode_switch_in(msw),
        .pos_x(px), .pos_y(py), .mode_out(mo), .heading_out(hd), .step_pulse(sp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            pulses += int'(sp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] x, input logic [2:0] y,
                             input logic m, input logic [3:0] h, input logic p);
        chk({tag, "_x"}, 8'(px), 8'(x));
        chk({tag, "_y"}, 8'(py), 8'(y));
        chk({tag, "_mode"}, 8'(mo), 8'(m));
        chk({tag, "_head"}, 8'(hd), 8'(h));
        chk({tag, "_pulse"}, 8'(sp), 8'(p));
    endtask

    initial begin
        // Reset, then release on a negedge: tick edges fall at E4, E8, E12, ...
        run(2);
        chk_state("rst", 0, 0, 0, DIR_NONE, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run(1);
            chk("idle_pulse", 8'(sp), 8'd0);
        end
        chk_state("idle_end", 0, 0, 0, DIR_NONE, 0);

        // HOLD right: heading appears after E23, steps at E24, E28, E32
        pulses = 0;
        dir = DIR_RIGHT;
        run(2);
        chk("lat_head0", 8'(hd), 8'(DIR_NONE));
        run(1);
        chk_state("hold_e23", 0, 0, 0, DIR_RIGHT, 0);
        run(1);
        chk_state("hold_e24", 1, 0, 0, DIR_RIGHT, 1);
        run(1);
        chk("hold_e25_pulse", 8'(sp), 8'd0);
        run(3);
        chk_state("hold_e28", 2, 0, 0, DIR_RIGHT, 1);
        run(4);
        chk_state("hold_e32", 3, 0, 0, DIR_RIGHT, 1);
        dir = DIR_NONE;
        run(3);
        chk("release_head", 8'(hd), 8'(DIR_NONE));
        run(5);
        chk_state("release_e40", 3, 0, 0, DIR_NONE, 0);
        chk("release_pulses", 8'(pulses), 8'd3);

        // Wrap: up at y=0, right through x=7, left at x=0
        dir = DIR_UP;
        run(4);
        chk_state("wrap_up", 3, 7, 0, DIR_UP, 1);
        dir = DIR_RIGHT;
        run(16);
        chk_state("right_to7", 7, 7, 0, DIR_RIGHT, 1);
        run(4);
        chk_state("wrap_right", 0, 7, 0, DIR_RIGHT, 1);
        dir = DIR_LEFT;
        run(4);
        chk_state("wrap_left", 7, 7, 0, DIR_LEFT, 1);

        // Multi-bit direction in HOLD is idle
        pulses = 0;
        dir = 4'b0011;
        run(3);
        chk("multi_head", 8'(hd), 8'(DIR_NONE));
        run(9);
        chk_state("multi_e80", 7, 7, 0, DIR_NONE, 0);
        chk("multi_pulses", 8'(pulses), 8'd0);

        // Mode edge held 10 cycles: toggles once at E83, latch cleared
        msw = 1'b1;
        run(3);
        chk_state("latch_on", 7, 7, 1, DIR_NONE, 0);
        run(7);
        chk("latch_hold_mode", 8'(mo), 8'd1);
        chk("latch_hold_head", 8'(hd), 8'(DIR_NONE));
        msw = 1'b0;
        dir = DIR_RIGHT;
        run(1);
        dir = 4'b0011;
        run(2);
        chk("latch_load", 8'(hd), 8'(DIR_RIGHT));
        run(3);
        chk_state("latch_e96", 0, 7, 1, DIR_RIGHT, 1);
        run(8);
        chk_state("latch_e104", 2, 7, 1, DIR_RIGHT, 1);
        dir = DIR_NONE;
        run(4);
        chk_state("latch_e108", 3, 7, 1, DIR_RIGHT, 1);

        // Second mode edge: back to HOLD, heading cleared, no motion
        pulses = 0;
        msw = 1'b1;
        run(3);
        chk_state("hold_back", 3, 7, 0, DIR_NONE, 0);
        run(5);
        chk("hold_back_x", 8'(px), 8'd3);
        chk("hold_back_pulses", 8'(pulses), 8'd0);

        // Toggle into LATCH with a valid direction in the same cycle: load wins
        msw = 1'b0;
        run(4);
        msw = 1'b1;
        dir = DIR_DOWN;
        run(3);
        chk_state("load_wins", 3, 7, 1, DIR_DOWN, 0);
        dir = DIR_NONE;
        run(1);
        chk_state("load_step", 3, 0, 1, DIR_DOWN, 1);

        // Asynchronous reset between edges clears everything immediately
        #2 reset_n = 1'b0;
        #1 chk_state("async_rst", 0, 0, 0, DIR_NONE, 0);
        @(negedge clk);
        msw = 1'b0;
        dir = DIR_RIGHT;
        reset_n = 1'b1;
        run(3);
        chk_state("resume_e3", 0, 0, 0, DIR_RIGHT, 0);
        run(1);
        chk_state("resume_e4", 1, 0, 0, DIR_RIGHT, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
